// File: rtl/stump_uart_tx_pkg.sv
// rtl/stump_uart_tx_pkg.sv - shared definitions for the Stump UART transmitter
//
// Contents: transmit FSM state encodings, register word offsets relative to
// BASE_ADDR, STATUS bit positions and the FIFO count saturation helper.
// No ports (package).

package stump_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } tx_state_e;

    localparam logic [15:0] OFS_TXDATA = 16'd0;
    localparam logic [15:0] OFS_STATUS = 16'd1;
    localparam logic [15:0] OFS_CTRL   = 16'd2;

    localparam int STATUS_FULL    = 0;
    localparam int STATUS_EMPTY   = 1;
    localparam int STATUS_BUSY    = 2;
    localparam int STATUS_OVF     = 3;
    localparam int STATUS_CNT_LSB = 4;
    localparam int STATUS_CNT_MSB = 6;

    localparam int CTRL_IRQ_EN = 0;

    // STATUS only has three bits for the count; deeper FIFOs report 7.
    function automatic logic [2:0] sat_count3(input logic [7:0] cnt);
        return (cnt > 8'd7) ? 3'd7 : cnt[2:0];
    endfunction

endpackage

// File: rtl/stump_uart_fifo.sv
// rtl/stump_uart_fifo.sv - synchronous FIFO holding bytes awaiting transmission
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset (empties the FIFO)
//   push_i   in   write data_i; ignored when full (full is sampled before pop)
//   data_i   in   WIDTH-bit write data
//   pop_i    in   discard head entry; ignored when empty
//   data_o   out  head entry (first-word fall-through)
//   full_o   out  FIFO holds DEPTH entries
//   empty_o  out  FIFO holds no entries
//   count_o  out  number of entries held

module stump_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage is not reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/stump_uart_tx.sv
// rtl/stump_uart_tx.sv - memory-mapped 8N1 serial transmitter on the Stump bus
//
// Registers (word addresses): TXDATA at BASE_ADDR, STATUS at BASE_ADDR+1,
// CTRL at BASE_ADDR+2. Optional interrupt support: STUMP_UART_TX_IRQ_EN.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   address  in   processor memory address
//   wdata    in   processor write data (data_out)
//   mem_wen  in   processor write enable
//   mem_ren  in   processor read enable
//   rdata    out  read data, 0 when not selected (ORed into data_in)
//   txd      out  serial line, idles high, registered
//   irq      out  level interrupt, only with STUMP_UART_TX_IRQ_EN

module stump_uart_tx
    import stump_uart_tx_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic        mem_wen,
    input  logic        mem_ren,
    output logic [15:0] rdata,
`ifdef STUMP_UART_TX_IRQ_EN
    output logic        irq,
`endif
    output logic        txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    logic hit_tx, hit_st, hit_ct;
    logic push_req, st_read;

    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count;

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;
    logic          baud_end, busy;
    logic [15:0]   status_word;
    logic          unused_bits;

    assign hit_tx = (address == BASE_ADDR + OFS_TXDATA);
    assign hit_st = (address == BASE_ADDR + OFS_STATUS);
    assign hit_ct = (address == BASE_ADDR + OFS_CTRL);

    assign push_req = mem_wen & hit_tx;
    assign st_read  = mem_ren & hit_st;

    assign unused_bits = ^{wdata[15:8], hit_ct};

    stump_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .data_i  (wdata[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_end = (baud_q == BAUD_LAST);
    assign busy     = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        baud_d   = baud_q;
        txd_d    = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_data;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit so queued bytes
                // go out back to back without an idle bit time.
                if (baud_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_data;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        if (state_d != state_q || state_q == ST_IDLE || baud_end) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BW'(1);
        end

        // txd is registered from the next state, so the line changes on
        // the same edge the FSM does.
        unique case (state_d)
            ST_IDLE:  txd_d = 1'b1;
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            ST_STOP:  txd_d = 1'b1;
        endcase
    end

    // A new overflow in the same cycle as a STATUS read keeps the flag set.
    assign ovf_d = (push_req & fifo_full) | (ovf_q & ~st_read);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign txd = txd_q;

`ifdef STUMP_UART_TX_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    assign irq_en_d = (mem_wen & hit_ct) ? wdata[CTRL_IRQ_EN] : irq_en_q;
    assign irq_d    = irq_en_q & fifo_empty & ~busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        status_word = 16'h0000;
        status_word[STATUS_FULL]  = fifo_full;
        status_word[STATUS_EMPTY] = fifo_empty;
        status_word[STATUS_BUSY]  = busy;
        status_word[STATUS_OVF]   = ovf_q;
        status_word[STATUS_CNT_MSB:STATUS_CNT_LSB] = sat_count3(8'(fifo_count));

        rdata = 16'h0000;
        if (mem_ren && hit_st) begin
            rdata = status_word;
        end
`ifdef STUMP_UART_TX_IRQ_EN
        if (mem_ren && hit_ct) begin
            rdata[CTRL_IRQ_EN] = irq_en_q;
        end
`endif
    end

endmodule

// File: tb/tb_stump_uart_tx.sv
// tb/tb_stump_uart_tx.sv - self-checking bench for stump_uart_tx (scoreboarded serial receiver)

module tb_stump_uart_tx;

    localparam int          CLK_DIV = 4;
    localparam int          FRAME   = 10 * CLK_DIV;
    localparam logic [15:0] BASE    = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        mem_wen = 1'b0;
    logic        mem_ren = 1'b0;
    wire  [15:0] rdata;
    wire         txd;
`ifdef STUMP_UART_TX_IRQ_EN
    wire         irq;
`endif

    stump_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .wdata   (wdata),
        .mem_wen (mem_wen),
        .mem_ren (mem_ren),
        .rdata   (rdata),
`ifdef STUMP_UART_TX_IRQ_EN
        .irq     (irq),
`endif
        .txd     (txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb_q[$];
    int         start_q[$];
    bit         rx_en = 1'b0;
    bit         rx_busy = 1'b0;
    int         rx_frames = 0;
    int         exp_frames = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b);
        sb_q.push_back(b);
        exp_frames++;
    endtask

    // Bus tasks are entered and left at a falling edge.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        address = a;
        wdata   = d;
        mem_wen = 1'b1;
        @(negedge clk);
        mem_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        address = a;
        mem_ren = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        mem_ren = 1'b0;
    endtask

    // Combinational look at STATUS without letting a clock edge see the read.
    task automatic peek_status(output logic [15:0] d);
        address = BASE + 16'd1;
        mem_ren = 1'b1;
        #1 d = rdata;
        mem_ren = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || rx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_sb_empty", sb_q.size(), 0);
        check("drain_rx_idle", rx_busy, 0);
    endtask

    // Serial receiver: samples the middle of each bit on falling edges.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_en && txd === 1'b0) begin
                rx_busy = 1'b1;
                start_q.push_back(cyc);
                repeat (CLK_DIV / 2) @(negedge clk);
                check("rx_start_bit", txd, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CLK_DIV) @(negedge clk);
                check("rx_stop_bit", txd, 1'b1);
                rx_frames++;
                check("rx_frame_expected", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    check("rx_byte", b, sb_q.pop_front());
                end
                repeat (CLK_DIV / 2 - 1) @(negedge clk);
                rx_busy = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [7:0]  frame_byte;
        int          errs;
        logic        exp_bit;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_txd", txd, 1'b1);

        // Idle after reset
        errs = 0;
        repeat (20) begin
            @(negedge clk);
            if (txd !== 1'b1) errs++;
        end
        check("idle_txd_low_cycles", errs, 0);
        bus_read(BASE + 16'd1, d);
        check("status_reset", d, 16'h0002);

        // Single frame with exact waveform
        rx_en = 1'b1;
        frame_byte = 8'h55;
        expect_byte(frame_byte);
        bus_write(BASE, 16'hAB55);
        check("txd_before_start", txd, 1'b1);
        errs = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (k < CLK_DIV) exp_bit = 1'b0;
            else if (k < 9 * CLK_DIV) exp_bit = frame_byte[(k - CLK_DIV) / CLK_DIV];
            else exp_bit = 1'b1;
            if (txd !== exp_bit) errs++;
            if (k == 20) begin
                peek_status(d);
                check("status_busy_mid_frame", d[2], 1'b1);
            end
        end
        check("frame0_waveform_errors", errs, 0);
        @(negedge clk);
        bus_read(BASE + 16'd1, d);
        check("status_after_frame", d, 16'h0002);
        wait_drain(200);
        check("frames_after_single", rx_frames, exp_frames);

        // Burst: one frame in flight, five more writes overflow a 4-deep FIFO
        start_q.delete();
        expect_byte(8'hC3);
        bus_write(BASE, 16'h00C3);
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) expect_byte(8'(i));
            bus_write(BASE, 16'(i));
        end
        bus_read(BASE + 16'd1, d);
        check("status_overflow", d, 16'h004D);
        bus_read(BASE + 16'd1, d);
        check("status_ovf_cleared", d, 16'h0045);
        wait_drain(1000);
        check("burst_frame_count", start_q.size(), 5);
        for (int i = 1; i < start_q.size(); i++) begin
            check("burst_gapless", start_q[i] - start_q[i-1], FRAME);
        end
        repeat (2) @(negedge clk);
        bus_read(BASE + 16'd1, d);
        check("status_after_burst", d, 16'h0002);

        // Reset in the middle of a frame discards everything
        rx_en = 1'b0;
        bus_write(BASE, 16'h005A);
        bus_write(BASE, 16'h0011);
        repeat (12) @(negedge clk);
        peek_status(d);
        check("status_before_rst", d, 16'h0014);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_frame_txd", txd, 1'b1);
        bus_read(BASE + 16'd1, d);
        check("status_after_rst", d, 16'h0002);
        errs = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (txd !== 1'b1) errs++;
        end
        check("no_frames_after_rst", errs, 0);

        // Decode corners
        bus_read(BASE + 16'd5, d);
        check("rdata_unmapped", d, 16'h0000);
        address = BASE + 16'd1;
        mem_ren = 1'b0;
        #1 check("rdata_no_ren", rdata, 16'h0000);
        bus_read(BASE, d);
        check("rdata_txdata", d, 16'h0000);
        bus_read(BASE + 16'd1, d);
        check("status_txdata_read_no_push", d, 16'h0002);

`ifdef STUMP_UART_TX_IRQ_EN
        check("irq_reset", irq, 1'b0);
        bus_write(BASE + 16'd2, 16'h0001);
        check("irq_not_yet", irq, 1'b0);
        @(negedge clk);
        check("irq_idle_enabled", irq, 1'b1);
        bus_read(BASE + 16'd2, d);
        check("ctrl_read", d, 16'h0001);
        rx_en = 1'b1;
        expect_byte(8'h3C);
        bus_write(BASE, 16'h003C);
        errs = 0;
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clk);
            if (irq !== 1'b0) errs++;
        end
        check("irq_low_during_frame", errs, 0);
        @(negedge clk);
        check("irq_after_idle", irq, 1'b1);
        bus_write(BASE + 16'd2, 16'h0000);
        check("irq_disable_lag", irq, 1'b1);
        @(negedge clk);
        check("irq_disabled", irq, 1'b0);
        wait_drain(200);
`else
        bus_write(BASE + 16'd2, 16'h0001);
        bus_read(BASE + 16'd2, d);
        check("ctrl_absent", d, 16'h0000);
`endif

        repeat (5) @(negedge clk);
        check("final_sb_empty", sb_q.size(), 0);
        check("final_frame_count", rx_frames, exp_frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
